pipearch_loadreg_multi: RTL and testbench

PIPEARCH_LOADREG_MULTI -- requirements
Module: pipearch_loadreg_multi

---
 rtl/pipearch_loadreg_multi.sv | 206 ++++++++++++++++++++
 tb/tb_pipearch_loadreg_multi.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipearch_loadreg_multi.sv
// rtl/pipearch_loadreg_multi.sv - multi-word register loader fed from a line-wide REGION read port
// Optional build macro: PIPEARCH_LOADREG_BOUNDS_CHECK_EN (drop out-of-range destinations, pulse op_error).
module pipearch_loadreg_multi #(
    parameter int WORD_WIDTH  = 32,
    parameter int LINE_WIDTH  = 512,
    parameter int NUM_OUTREGS = 8,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_start,
    output logic                  op_done,
    output logic                  op_error,
    input  logic [31:0]           regs [3],
    output logic [WORD_WIDTH-1:0] outregs [NUM_OUTREGS],
    output logic                  REGION_read_re,
    output logic [ADDR_WIDTH-1:0] REGION_read_raddr,
    output logic [1:0]            REGION_read_rfifobram,
    input  logic                  REGION_read_rvalid,
    input  logic [LINE_WIDTH-1:0] REGION_read_rdata
);

    localparam int WPL    = LINE_WIDTH / WORD_WIDTH;
    localparam int POS_W  = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int OIDX_W = (NUM_OUTREGS > 1) ? $clog2(NUM_OUTREGS) : 1;
    // First index is 16 bits and up to 255 more words follow, so 17 bits never overflow.
    localparam int IDX_W  = 17;
    // Destination base is 8 bits plus up to 255 words: 9 bits keep the true index for range checks.
    localparam int DST_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_RECEIVE,
        ST_EXTRACT
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DST_W-1:0]        dst_q, dst_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [15:0]             off_q, off_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic                    re_q, re_d;
    logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    error_q, error_d;
    logic [WORD_WIDTH-1:0]   outregs_q [NUM_OUTREGS];

    logic                    wr_en;
    logic [OIDX_W-1:0]       wr_idx;
    logic [WORD_WIDTH-1:0]   wr_data;

    logic [POS_W-1:0]        pos;
    logic [IDX_W-1:0]        line_num;
    logic [LINE_WIDTH-1:0]   src_line;
    logic [WORD_WIDTH-1:0]   word;
    logic                    take;
    logic                    last_word;
    logic                    at_line_end;
    logic                    start_err;
    logic                    dest_ok;
    logic                    unused_regs;

    assign unused_regs = ^{regs[0][31:16], regs[1][31:16], regs[2][31:16]};

`ifdef PIPEARCH_LOADREG_BOUNDS_CHECK_EN
    assign start_err = (32'(regs[1][7:0]) + 32'(regs[1][15:8])) > 32'(NUM_OUTREGS);
    assign dest_ok   = 32'(dst_q) < 32'(NUM_OUTREGS);
`else
    assign start_err = 1'b0;
    assign dest_ok   = 1'b1;
`endif

    // Word selection: the freshly returned line in RECEIVE, the buffered line in EXTRACT.
    always_comb begin
        pos         = POS_W'(idx_q % IDX_W'(WPL));
        line_num    = idx_q / IDX_W'(WPL);
        src_line    = (state_q == ST_RECEIVE) ? REGION_read_rdata : line_q;
        word        = src_line[pos * WORD_WIDTH +: WORD_WIDTH];
        last_word   = (cnt_q == 8'd1);
        at_line_end = (pos == POS_W'(WPL - 1));
    end

    // Next-state and datapath control for the load sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        line_d  = line_q;
        re_d    = 1'b0;
        raddr_d = raddr_q;
        done_d  = 1'b0;
        err_d   = err_q;
        error_d = 1'b0;
        take    = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;

        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    idx_d = {1'b0, regs[0][15:0]};
                    dst_d = {1'b0, regs[1][7:0]};
                    cnt_d = regs[1][15:8];
                    off_d = regs[2][15:0];
                    err_d = start_err;
                    if (regs[1][15:8] == 8'd0) begin
                        // Nothing to load: finish right away without touching the read port.
                        done_d  = 1'b1;
                        error_d = start_err;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                re_d    = 1'b1;
                raddr_d = ADDR_WIDTH'(32'(off_q) + 32'(line_num));
                state_d = ST_RECEIVE;
            end
            ST_RECEIVE: begin
                if (REGION_read_rvalid) begin
                    line_d = REGION_read_rdata;
                    take   = 1'b1;
                end
            end
            ST_EXTRACT: begin
                take = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take) begin
            wr_en   = dest_ok;
            wr_idx  = OIDX_W'(dst_q);
            wr_data = word;
            idx_d   = idx_q + IDX_W'(1);
            dst_d   = dst_q + DST_W'(1);
            cnt_d   = cnt_q - 8'd1;
            if (last_word) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                error_d = err_q;
            end else if (at_line_end) begin
                state_d = ST_READ;
            end else begin
                state_d = ST_EXTRACT;
            end
        end
    end

    // State and control registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            off_q   <= '0;
            line_q  <= '0;
            re_q    <= 1'b0;
            raddr_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            line_q  <= line_d;
            re_q    <= re_d;
            raddr_q <= raddr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            error_q <= error_d;
        end
    end

    // Output register file: one word written per accepted word slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_OUTREGS; r++) begin
                outregs_q[r] <= '0;
            end
        end else if (wr_en) begin
            outregs_q[wr_idx] <= wr_data;
        end
    end

    assign outregs               = outregs_q;
    assign op_done               = done_q;
    assign op_error              = error_q;
    assign REGION_read_re        = re_q;
    assign REGION_read_raddr     = raddr_q;
    assign REGION_read_rfifobram = 2'b01;

endmodule

// File: tb/tb_pipearch_loadreg_multi.sv
// tb/tb_pipearch_loadreg_multi.sv - self-checking bench for pipearch_loadreg_multi
module tb_pipearch_loadreg_multi;

    localparam int WW  = 32;
    localparam int LW  = 512;
    localparam int NO  = 8;
    localparam int AW  = 16;
    localparam int WPL = LW / WW;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_start;
    logic          op_done;
    logic          op_error;
    logic [31:0]   regs [3];
    logic [WW-1:0] outregs [NO];
    logic          re;
    logic [AW-1:0] raddr;
    logic [1:0]    rfb;
    logic          rvalid;
    logic [LW-1:0] rdata;

    pipearch_loadreg_multi #(
        .WORD_WIDTH (WW),
        .LINE_WIDTH (LW),
        .NUM_OUTREGS(NO),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .op_start             (op_start),
        .op_done              (op_done),
        .op_error             (op_error),
        .regs                 (regs),
        .outregs              (outregs),
        .REGION_read_re       (re),
        .REGION_read_raddr    (raddr),
        .REGION_read_rfifobram(rfb),
        .REGION_read_rvalid   (rvalid),
        .REGION_read_rdata    (rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [31:0]   seed;
    int            resp_delay = 0;
    int            re_count = 0;
    int            re_cyc = 0;
    int            rvalid_cyc = 0;
    int            stray_cnt = 0;
    logic [AW-1:0] addr_log [$];
    logic [AW-1:0] exp_addrs [$];
    logic [WW-1:0] model_regs [NO];

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a, input int p);
        if (a == 16'd3 && p == 5) return 32'hDEADBEEF;
        return (32'(a) * 32'h9E3779B1) ^ (32'(p) * 32'h85EBCA6B) ^ seed;
    endfunction

    function automatic logic [LW-1:0] build_line(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        l = '0;
        for (int p = 0; p < WPL; p++) l[p*WW +: WW] = mem_word(a, p);
        return l;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: word k goes from line (I+k)/WPL, slot (I+k)%WPL to register D+k.
    task automatic model_op(input int I, input int D, input int N, input int O, output bit exp_err);
        exp_addrs = {};
        for (int k = 0; k < N; k++) begin
            int idx;
            int line;
            int pos;
            int d;
            logic [AW-1:0] a;
            idx  = I + k;
            line = idx / WPL;
            pos  = idx % WPL;
            d    = D + k;
            a    = AW'(O + line);
            if (k == 0 || pos == 0) exp_addrs.push_back(a);
`ifdef PIPEARCH_LOADREG_BOUNDS_CHECK_EN
            if (d < NO) model_regs[d] = mem_word(a, pos);
`else
            model_regs[d % NO] = mem_word(a, pos);
`endif
        end
`ifdef PIPEARCH_LOADREG_BOUNDS_CHECK_EN
        exp_err = (D + N) > NO;
`else
        exp_err = 1'b0;
`endif
    endtask

    task automatic run_op(input int I, input int D, input int N, input int O,
                          input int delay, input bit busy_starts, input bit lat_check);
        int  base;
        int  rc0;
        int  t0;
        int  done_cyc;
        int  waited;
        bit  exp_err;
        resp_delay = delay;
        base = addr_log.size();
        rc0  = re_count;
        model_op(I, D, N, O, exp_err);
        @(negedge clk);
        regs[0]  = 32'(I[15:0]);
        regs[1]  = {16'h0, N[7:0], D[7:0]};
        regs[2]  = 32'(O[15:0]);
        op_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        op_start = 1'b0;
        waited = 0;
        while (op_done !== 1'b1 && waited < 2000) begin
            if (busy_starts) begin
                op_start = (waited % 3 == 0);
                regs[0]  = $urandom;
                regs[1]  = $urandom;
                regs[2]  = $urandom;
            end
            @(negedge clk);
            waited++;
        end
        op_start = 1'b0;
        done_cyc = cyc;
        check("op_done_seen", op_done, 1'b1);
        check("op_error_at_done", op_error, exp_err);
        if (N == 0) check("n0_done_latency", done_cyc - t0, 1);
        if (lat_check) begin
            check("re_latency", re_cyc - t0, 2);
            check("done_after_rvalid", done_cyc - rvalid_cyc, 1);
        end
        @(negedge clk);
        check("op_done_single", op_done, 1'b0);
        check("op_error_single", op_error, 1'b0);
        repeat (4) @(negedge clk);
        check("op_done_quiet", op_done, 1'b0);
        check("re_count", re_count - rc0, exp_addrs.size());
        for (int i = 0; i < exp_addrs.size() && base + i < addr_log.size(); i++)
            check("raddr", addr_log[base + i], exp_addrs[i]);
        for (int r = 0; r < NO; r++) check($sformatf("outreg%0d", r), outregs[r], model_regs[r]);
        check("rfifobram", rfb, 2'b01);
    endtask

    // REGION memory: one outstanding read, answered after resp_delay cycles.
    initial begin
        logic [AW-1:0] a;
        int            stray_seen;
        stray_seen = 0;
        rvalid = 1'b0;
        rdata  = '0;
        forever begin
            @(negedge clk);
            if (stray_seen != stray_cnt) begin
                stray_seen = stray_cnt;
                rvalid = 1'b1;
                rdata  = {16{32'hBAD0BAD0}};
                @(negedge clk);
                rvalid = 1'b0;
            end else if (re === 1'b1) begin
                a = raddr;
                re_count++;
                re_cyc = cyc;
                addr_log.push_back(a);
                repeat (resp_delay) @(negedge clk);
                rvalid = 1'b1;
                rdata  = build_line(a);
                rvalid_cyc = cyc;
                @(negedge clk);
                rvalid = 1'b0;
            end
        end
    end

    initial begin
        int waited;
        int rc0;
        seed     = $urandom;
        reset    = 1'b1;
        op_start = 1'b0;
        regs[0]  = '0;
        regs[1]  = '0;
        regs[2]  = '0;
        for (int r = 0; r < NO; r++) model_regs[r] = '0;
        repeat (3) @(negedge clk);
        check("rst_op_done", op_done, 1'b0);
        check("rst_op_error", op_error, 1'b0);
        check("rst_re", re, 1'b0);
        check("rst_raddr", raddr, '0);
        check("rst_rfifobram", rfb, 2'b01);
        for (int r = 0; r < NO; r++) check("rst_outreg", outregs[r], '0);
        reset = 1'b0;

        // Single word, minimum latency, known pattern.
        run_op(53, 2, 1, 0, 0, 1'b0, 1'b1);
        check("deadbeef", outregs[2], 32'hDEADBEEF);

        // Four words spanning two lines.
        run_op(14, 0, 4, 10, 0, 1'b0, 1'b0);

        // Zero-length operation.
        run_op(100, 3, 0, 7, 0, 1'b0, 1'b0);

        // Slow memory with start pulses while busy.
        run_op(30, 1, 5, 200, 20, 1'b1, 1'b0);

        // Reset while extracting: two of four words written.
        resp_delay = 2;
        rc0 = re_count;
        @(negedge clk);
        regs[0]  = 32;
        regs[1]  = {16'h0, 8'd4, 8'd4};
        regs[2]  = 5;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        waited = 0;
        while (outregs[5] !== mem_word(16'd7, 1) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("mid_op_progress", outregs[5], mem_word(16'd7, 1));
        check("mid_op_not_done", outregs[6] === mem_word(16'd7, 2), 1'b0);
        #2;
        reset = 1'b1;
        #1;
        for (int r = 0; r < NO; r++) check("midrst_outreg", outregs[r], '0);
        check("midrst_re", re, 1'b0);
        check("midrst_raddr", raddr, '0);
        check("midrst_op_done", op_done, 1'b0);
        check("midrst_op_error", op_error, 1'b0);
        for (int r = 0; r < NO; r++) model_regs[r] = '0;
        @(negedge clk);
        reset = 1'b0;
        stray_cnt++;
        repeat (6) @(negedge clk);
        check("stray_no_done", op_done, 1'b0);
        check("stray_no_re", re_count - rc0, 1);
        for (int r = 0; r < NO; r++) check("stray_outreg", outregs[r], '0);
        run_op(40, 0, 3, 9, 1, 1'b0, 1'b0);

        // Destination range overflow.
        run_op(7, 6, 4, 33, 0, 1'b0, 1'b0);

        // Address wrap past the top of the read space.
        run_op(65530, 1, 10, 16'hFFFF, 0, 1'b0, 1'b0);

        // Randomised operations.
        for (int t = 0; t < 10; t++) begin
            run_op($urandom_range(0, 65535), $urandom_range(0, 11), $urandom_range(0, 20),
                   $urandom_range(0, 65535), $urandom_range(0, 3), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
